cpu_core_p: RTL and testbench
=============================

// Module: cpu_core_p
// PURPOSE
//  Parametrised multicycle CPU core; next generation of the 8-bit cpu top.
//  Generic data/address width and register count. Separate req/ack handshakes
//    for instruction and data memory replace the inout user bus.
//  Adds maskable vectored interrupt with EPC save/RETI, HALT, carry/zero flags.
//  Sits between instruction ROM, data RAM and the interrupt source at SoC top.
// PARAMETERS
//  DATA_W   8      datapath / register / data-memory word width
//  ADDR_W   8      PC and memory address width (PC wraps modulo 2**ADDR_W)
//  NREGS    4      register-file entries (power of 2, >=2); RSEL_W=$clog2(NREGS)
//  IRQ_VEC  'hF0   PC loaded on interrupt entry (ADDR_W bits)
//  INSTR_W  (derived localparam) 4+2*RSEL_W+max(DATA_W,ADDR_W): {op,rd,rs,imm}
// PORTS
//  clk         in   1        rising-edge clock
//  reset       in   1        asynchronous, active-high
//  interrupt   in   1        level IRQ request
//  imem_req    out  1        instruction fetch request
//  imem_addr   out  ADDR_W   fetch address (= PC)
//  imem_rdata  in   INSTR_W  instruction, valid when imem_ack=1
//  imem_ack    in   1        fetch complete (may assert same cycle as req)
//  dmem_req    out  1        data access request
//  dmem_we     out  1        1=store, 0=load
//  dmem_addr   out  ADDR_W   data address (imm)
//  dmem_wdata  out  DATA_W   store data (R[rd])
//  dmem_rdata  in   DATA_W   load data, valid when dmem_ack=1
//  dmem_ack    in   1        data access complete
//  halted      out  1        core in HALT state
// BEHAVIOUR
//  Reset (async): PC=0, all R=0, Z=C=0, IE=0, EPC=0, state=FETCH, all req=0, halted=0.
//  Request rule: req held high, addr/we/wdata stable, until ack sampled high; drop next cycle.
//  FSM: FETCH -> EXEC -> (MEM ->) FETCH; HALT; IRQ.
//   FETCH: on entry, if interrupt&IE -> IRQ (no fetch). Else imem_req=1; on ack latch IR, PC+=1.
//   EXEC (1 cycle): ALU ops write R[rd], update Z (and C for ADD/SUB); LD/ST -> MEM.
//   MEM: dmem_req=1; on ack LD writes R[rd]=dmem_rdata, Z updated; -> FETCH.
//   IRQ (1 cycle): EPC=PC, IE=0, PC=IRQ_VEC -> FETCH.
//   HALT: halted=1, no requests; leaves to IRQ when interrupt&IE, else only by reset.
//  Opcodes: 0 NOP | 1 ADD rd+=rs | 2 SUB rd-=rs (C=borrow) | 3 AND | 4 OR | 5 XOR
//   6 LDI rd=imm | 7 LD rd=M[imm] | 8 ST M[imm]=rd | 9 JMP PC=imm | A JZ if Z PC=imm
//   B SHL rd<<=1 (C=msb out) | C SHR rd>>=1 (C=lsb out) | D EI/DI (imm[0]->IE)
//   E RETI PC=EPC, IE=1 | F HALT.
//  Arithmetic modulo 2**DATA_W; Z=(result==0). Logic/LDI clear C; flags unchanged by
//   NOP/ST/JMP/JZ/EI/RETI.
//  Latency (ack same cycle as req): 2 cycles/instr, 3 for LD/ST; +1 per wait cycle.
//  Boundaries: PC=2**ADDR_W-1 fetch wraps PC to 0; IRQ taken only at instruction boundary,
//   never mid-MEM; IRQ during wait states is deferred; EI takes effect for the next boundary.
//   Reset mid-request drops req immediately.
//  Nested IRQ impossible (IE=0 on entry); RETI with IE already 1 is legal.
// STRUCTURE
//  Package cpu_core_pkg: opcode constants, state encoding, INSTR field-offset functions.
//  One sub-module alu_p #(DATA_W): combinational op/a/b -> result, z, c.
//  Register file and FSM inline in cpu_core_p.
// TESTING
//  1 LDI R1,5; LDI R2,3; ADD R1,R2 -> R1=8, Z=0, C=0; 2 cycles/instr with zero-wait acks.
//  2 LDI R0,FF; LDI R1,1; ADD R0,R1 -> R0=0, Z=1, C=1; JZ 20 -> next imem_addr=20.
//  3 ST R1->M[40] with dmem_ack delayed 3 cycles -> req/we/addr/wdata held 4 cycles,
//    then LD R2,M[40] -> R2=8.
//  4 EI; interrupt=1 while PC=12 -> EPC=12, PC=F0, IE=0; RETI -> fetch at 12, IE=1.
//  5 HALT with IE=0 -> halted=1, no reqs for 20 cycles; EI before HALT + interrupt
//    -> exit to F0.
//  6 JMP FF; NOP at FF -> next fetch addr 00; reset asserted mid-MEM -> req=0,
//    PC=0 same cycle.

Source files
------------

// File: rtl/cpu_core_pkg.sv
// rtl/cpu_core_pkg.sv - opcodes, FSM state encoding and instruction field helpers
package cpu_core_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_SHL  = 4'hB;
  localparam logic [3:0] OP_SHR  = 4'hC;
  localparam logic [3:0] OP_EI   = 4'hD;
  localparam logic [3:0] OP_RETI = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ST_FETCH = 3'd0;
  localparam logic [2:0] ST_EXEC  = 3'd1;
  localparam logic [2:0] ST_MEM   = 3'd2;
  localparam logic [2:0] ST_IRQ   = 3'd3;
  localparam logic [2:0] ST_HALT  = 3'd4;

  // Immediate must hold both a data constant and an address.
  function automatic int imm_width(int data_w, int addr_w);
    return (data_w > addr_w) ? data_w : addr_w;
  endfunction

  // Instruction layout is {op[3:0], rd, rs, imm}, imm in the low bits.
  function automatic int instr_width(int rsel_w, int imm_w);
    return 4 + 2 * rsel_w + imm_w;
  endfunction

  function automatic int op_lsb(int rsel_w, int imm_w);
    return 2 * rsel_w + imm_w;
  endfunction

  function automatic int rd_lsb(int rsel_w, int imm_w);
    return rsel_w + imm_w;
  endfunction

  function automatic int rs_lsb(int imm_w);
    return imm_w;
  endfunction

endpackage

// File: rtl/cpu_core_p_if.sv
// rtl/cpu_core_p_if.sv - instruction and data memory request/ack bus
interface cpu_core_p_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ack;
  logic               dmem_req;
  logic               dmem_we;
  logic [ADDR_W-1:0]  dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic [DATA_W-1:0]  dmem_rdata;
  logic               dmem_ack;

  modport master (
    output imem_req, imem_addr, input imem_rdata, imem_ack,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_rdata, dmem_ack
  );

  modport slave (
    input imem_req, imem_addr, output imem_rdata, imem_ack,
    input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/alu_p.sv
// rtl/alu_p.sv - combinational ALU producing result, zero and carry/borrow
module alu_p
  import cpu_core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c
);

  logic [DATA_W:0] wide;

  // Carry is the bit shifted or carried out; logic ops and LDI leave it clear.
  always_comb begin
    wide   = '0;
    result = a;
    c      = 1'b0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
      end
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_LDI: result = b;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        c      = a[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        c      = a[0];
      end
      default: ;
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/cpu_core_p.sv
// rtl/cpu_core_p.sv - parametrised multicycle CPU core with vectored interrupt
module cpu_core_p
  import cpu_core_pkg::*;
#(
  parameter int              DATA_W  = 8,
  parameter int              ADDR_W  = 8,
  parameter int              NREGS   = 4,
  parameter logic [ADDR_W-1:0] IRQ_VEC = 'hF0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          interrupt,
  cpu_core_p_if.master  bus,
  output logic          halted
);

  localparam int RSEL_W  = $clog2(NREGS);
  localparam int IMM_W   = imm_width(DATA_W, ADDR_W);
  localparam int INSTR_W = instr_width(RSEL_W, IMM_W);
  localparam int OP_LSB  = op_lsb(RSEL_W, IMM_W);
  localparam int RD_LSB  = rd_lsb(RSEL_W, IMM_W);
  localparam int RS_LSB  = rs_lsb(IMM_W);

  logic [2:0]         state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  epc;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  regs [NREGS];
  logic               z;
  logic               c;
  logic               ie;

  logic [3:0]         op;
  logic [RSEL_W-1:0]  rd;
  logic [RSEL_W-1:0]  rs;
  logic [IMM_W-1:0]   imm;
  logic [DATA_W-1:0]  rd_val;
  logic [DATA_W-1:0]  alu_b;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_z;
  logic               alu_c;
  logic               writes_rd;
  logic [ADDR_W-1:0]  pc_next;
  logic               ie_next;

  assign op     = ir[OP_LSB +: 4];
  assign rd     = ir[RD_LSB +: RSEL_W];
  assign rs     = ir[RS_LSB +: RSEL_W];
  assign imm    = ir[IMM_W-1:0];
  assign rd_val = regs[rd];
  assign alu_b  = (op == OP_LDI) ? imm[DATA_W-1:0] : regs[rs];

  assign bus.imem_addr = pc;
  assign halted        = (state == ST_HALT);

  alu_p #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (rd_val),
    .b      (alu_b),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c)
  );

  // Decode: which ops write rd/flags, and the PC/IE values after EXEC.
  always_comb begin
    writes_rd = 1'b0;
    pc_next   = pc;
    ie_next   = ie;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_LDI, OP_SHL, OP_SHR: writes_rd = 1'b1;
      OP_JMP:  pc_next = imm[ADDR_W-1:0];
      OP_JZ:   if (z) pc_next = imm[ADDR_W-1:0];
      OP_EI:   ie_next = imm[0];
      OP_RETI: begin
        pc_next = epc;
        ie_next = 1'b1;
      end
      default: ;
    endcase
  end

  // Main FSM; the interrupt is checked only where an instruction completes,
  // so the next fetch request can be raised on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_FETCH;
      pc             <= '0;
      epc            <= '0;
      ir             <= '0;
      z              <= 1'b0;
      c              <= 1'b0;
      ie             <= 1'b0;
      bus.imem_req   <= 1'b0;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (bus.imem_req) begin
            if (bus.imem_ack) begin
              ir           <= bus.imem_rdata;
              pc           <= pc + 1'b1;
              bus.imem_req <= 1'b0;
              state        <= ST_EXEC;
            end
          end else if (interrupt && ie) begin
            state <= ST_IRQ;
          end else begin
            bus.imem_req <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (writes_rd) begin
            regs[rd] <= alu_res;
            z        <= alu_z;
            c        <= alu_c;
          end
          pc <= pc_next;
          ie <= ie_next;
          if (op == OP_LD || op == OP_ST) begin
            state          <= ST_MEM;
            bus.dmem_req   <= 1'b1;
            bus.dmem_we    <= (op == OP_ST);
            bus.dmem_addr  <= imm[ADDR_W-1:0];
            bus.dmem_wdata <= rd_val;
          end else if (op == OP_HALT) begin
            state <= ST_HALT;
          end else if (interrupt && ie_next) begin
            state <= ST_IRQ;
          end else begin
            state        <= ST_FETCH;
            bus.imem_req <= 1'b1;
          end
        end
        ST_MEM: begin
          if (bus.dmem_ack) begin
            bus.dmem_req <= 1'b0;
            if (!bus.dmem_we) begin
              regs[rd] <= bus.dmem_rdata;
              z        <= (bus.dmem_rdata == '0);
            end
            if (interrupt && ie) begin
              state <= ST_IRQ;
            end else begin
              state        <= ST_FETCH;
              bus.imem_req <= 1'b1;
            end
          end
        end
        ST_IRQ: begin
          epc          <= pc;
          ie           <= 1'b0;
          pc           <= IRQ_VEC;
          state        <= ST_FETCH;
          bus.imem_req <= 1'b1;
        end
        ST_HALT: begin
          if (interrupt && ie) state <= ST_IRQ;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_p.sv
// tb/tb_cpu_core_p.sv - directed vector bench for cpu_core_p
module tb_cpu_core_p;

  localparam logic [3:0] NOP = 4'h0, ADD = 4'h1, SUB = 4'h2, AND_ = 4'h3, OR_ = 4'h4;
  localparam logic [3:0] XOR_ = 4'h5, LDI = 4'h6, LD = 4'h7, ST = 4'h8, JMP = 4'h9;
  localparam logic [3:0] JZ = 4'hA, SHL = 4'hB, SHR = 4'hC, EI = 4'hD, RETI = 4'hE, HALT = 4'hF;

  logic clk;
  logic reset;
  logic interrupt;
  logic halted;

  cpu_core_p_if #(.DATA_W(8), .ADDR_W(8), .INSTR_W(16)) bus ();

  cpu_core_p #(.DATA_W(8), .ADDR_W(8), .NREGS(4), .IRQ_VEC(8'hF0)) dut (
    .clk       (clk),
    .reset     (reset),
    .interrupt (interrupt),
    .bus       (bus),
    .halted    (halted)
  );

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       c;
  } vec_t;

  vec_t vt[10];

  logic [15:0] imem [256];
  logic [7:0]  dmem [256];
  int          ddelay;
  int          dcnt;
  int          st_cycles, st_chg, ld_cycles;
  logic [7:0]  st_addr, st_wdata;

  int nchk;
  int nfail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: instruction ack in the request cycle, data ack after ddelay waits.
  always @(negedge clk) begin
    if (reset) begin
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      dcnt = 0;
      st_cycles = 0;
      st_chg = 0;
      ld_cycles = 0;
    end else begin
      bus.imem_ack = bus.imem_req;
      if (bus.imem_req) bus.imem_rdata = imem[bus.imem_addr];
      if (bus.dmem_req && bus.dmem_we) begin
        if (st_cycles > 0 && (bus.dmem_addr != st_addr || bus.dmem_wdata != st_wdata)) st_chg++;
        st_addr  = bus.dmem_addr;
        st_wdata = bus.dmem_wdata;
        st_cycles++;
      end
      if (bus.dmem_req && !bus.dmem_we) ld_cycles++;
      if (bus.dmem_req && dcnt >= ddelay) begin
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = dmem[bus.dmem_addr];
        if (bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
        dcnt = 0;
      end else begin
        bus.dmem_ack = 1'b0;
        dcnt = bus.dmem_req ? dcnt + 1 : 0;
      end
    end
  end

  function automatic logic [15:0] enc(logic [3:0] op, logic [1:0] rd, logic [1:0] rs, logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic vec_t mk(string name, logic [3:0] op, logic [7:0] a, logic [7:0] b,
                              logic [7:0] res, logic z, logic c);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.res = res; v.z = z; v.c = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) imem[i] = {HALT, 12'h000};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_halt(output int cyc);
    cyc = 0;
    while (!halted && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_fetch(output logic [7:0] a, output bit ok);
    ok = 1'b0;
    a  = '0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      #1;
      if (bus.imem_req && bus.imem_ack) begin
        ok = 1'b1;
        a  = bus.imem_addr;
      end
    end
  endtask

  task automatic wait_fetch_at(input logic [7:0] target, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      #1;
      if (bus.imem_req && bus.imem_ack && bus.imem_addr == target) ok = 1'b1;
    end
  endtask

  initial begin
    int         cyc;
    bit         ok;
    logic [7:0] a;
    int         bad;

    nchk = 0;
    nfail = 0;
    reset = 1'b1;
    interrupt = 1'b0;
    ddelay = 0;
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;

    vt[0] = mk("add_5_3",   ADD,  8'h05, 8'h03, 8'h08, 1'b0, 1'b0);
    vt[1] = mk("add_ff_1",  ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    vt[2] = mk("sub_3_5",   SUB,  8'h03, 8'h05, 8'hFE, 1'b0, 1'b1);
    vt[3] = mk("sub_7_7",   SUB,  8'h07, 8'h07, 8'h00, 1'b1, 1'b0);
    vt[4] = mk("and",       AND_, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    vt[5] = mk("or_zero",   OR_,  8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    vt[6] = mk("xor",       XOR_, 8'hA5, 8'hFF, 8'h5A, 1'b0, 1'b0);
    vt[7] = mk("shl_81",    SHL,  8'h81, 8'h00, 8'h02, 1'b0, 1'b1);
    vt[8] = mk("shr_01",    SHR,  8'h01, 8'h00, 8'h00, 1'b1, 1'b1);
    vt[9] = mk("nop",       NOP,  8'h05, 8'h07, 8'h05, 1'b0, 1'b0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", bus.imem_req, 1'b0);
    chk("rst_dmem_req", bus.dmem_req, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_pc", dut.pc, 8'h00);

    // Table: LDI R1,a; LDI R2,b; op R1,R2; HALT.
    for (int i = 0; i < 10; i++) begin
      clear_prog();
      imem[0] = enc(LDI, 2'd1, 2'd0, vt[i].a);
      imem[1] = enc(LDI, 2'd2, 2'd0, vt[i].b);
      imem[2] = enc(vt[i].op, 2'd1, 2'd2, 8'h00);
      do_reset();
      wait_halt(cyc);
      chk({vt[i].name, "_r1"}, dut.regs[1], vt[i].res);
      chk({vt[i].name, "_z"}, dut.z, vt[i].z);
      chk({vt[i].name, "_c"}, dut.c, vt[i].c);
      chk({vt[i].name, "_cycles"}, cyc, 9);
    end

    // ADD to zero, then JZ taken.
    clear_prog();
    imem[0] = enc(LDI, 2'd0, 2'd0, 8'hFF);
    imem[1] = enc(LDI, 2'd1, 2'd0, 8'h01);
    imem[2] = enc(ADD, 2'd0, 2'd1, 8'h00);
    imem[3] = enc(JZ, 2'd0, 2'd0, 8'h20);
    imem[4] = enc(LDI, 2'd3, 2'd0, 8'h77);
    do_reset();
    wait_halt(cyc);
    chk("jz_r0", dut.regs[0], 8'h00);
    chk("jz_c", dut.c, 1'b1);
    chk("jz_pc", dut.pc, 8'h21);
    chk("jz_skip_r3", dut.regs[3], 8'h00);

    // Store/load with 3 wait states on the data bus.
    clear_prog();
    ddelay = 3;
    imem[0] = enc(LDI, 2'd1, 2'd0, 8'h08);
    imem[1] = enc(ST, 2'd1, 2'd0, 8'h40);
    imem[2] = enc(LD, 2'd2, 2'd0, 8'h40);
    do_reset();
    wait_halt(cyc);
    chk("mem_cycles", cyc, 17);
    chk("st_req_cycles", st_cycles, 4);
    chk("st_stable", st_chg, 0);
    chk("st_addr", st_addr, 8'h40);
    chk("st_wdata", st_wdata, 8'h08);
    chk("ld_req_cycles", ld_cycles, 4);
    chk("ld_r2", dut.regs[2], 8'h08);
    chk("dmem_40", dmem[8'h40], 8'h08);
    ddelay = 0;

    // Reset clears registers left over from the previous program.
    reset = 1'b1;
    #1;
    chk("rst_r1", dut.regs[1], 8'h00);
    chk("rst_state", dut.state, 3'd0);

    // EI, interrupt at PC=12, handler at F0, RETI back to 12.
    clear_prog();
    imem[8'h00] = enc(EI, 2'd0, 2'd0, 8'h01);
    imem[8'h01] = enc(JMP, 2'd0, 2'd0, 8'h10);
    imem[8'h10] = enc(NOP, 2'd0, 2'd0, 8'h00);
    imem[8'h11] = enc(NOP, 2'd0, 2'd0, 8'h00);
    imem[8'h12] = enc(LDI, 2'd3, 2'd0, 8'h33);
    imem[8'hF0] = enc(LDI, 2'd2, 2'd0, 8'h22);
    imem[8'hF1] = enc(RETI, 2'd0, 2'd0, 8'h00);
    do_reset();
    wait_fetch_at(8'h11, ok);
    chk("irq_reach_11", ok, 1'b1);
    interrupt = 1'b1;
    wait_fetch_at(8'hF0, ok);
    chk("irq_vec_fetch", ok, 1'b1);
    chk("irq_epc", dut.epc, 8'h12);
    chk("irq_ie_off", dut.ie, 1'b0);
    interrupt = 1'b0;
    wait_halt(cyc);
    chk("irq_handler_r2", dut.regs[2], 8'h22);
    chk("reti_r3", dut.regs[3], 8'h33);
    chk("reti_ie", dut.ie, 1'b1);
    chk("reti_pc", dut.pc, 8'h14);

    // HALT with IE=0 ignores the interrupt and stays quiet.
    clear_prog();
    interrupt = 1'b1;
    do_reset();
    wait_halt(cyc);
    chk("halt_ie0", halted, 1'b1);
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.imem_req || bus.dmem_req || !halted) bad++;
    end
    chk("halt_quiet", bad, 0);

    // HALT with IE=1 leaves to the vector on interrupt.
    interrupt = 1'b0;
    clear_prog();
    imem[8'h00] = enc(EI, 2'd0, 2'd0, 8'h01);
    imem[8'hF0] = enc(LDI, 2'd1, 2'd0, 8'h5A);
    do_reset();
    wait_halt(cyc);
    chk("halt_ie1_pc", dut.pc, 8'h02);
    interrupt = 1'b1;
    wait_fetch_at(8'hF0, ok);
    chk("halt_exit_f0", ok, 1'b1);
    interrupt = 1'b0;
    wait_halt(cyc);
    chk("halt_exit_r1", dut.regs[1], 8'h5A);
    chk("halt_exit_epc", dut.epc, 8'h02);
    chk("halt_exit_pc", dut.pc, 8'hF2);

    // PC wrap from FF to 00.
    clear_prog();
    imem[8'h00] = enc(JZ, 2'd0, 2'd0, 8'h30);
    imem[8'h01] = enc(SUB, 2'd0, 2'd0, 8'h00);
    imem[8'h02] = enc(JMP, 2'd0, 2'd0, 8'hFF);
    imem[8'hFF] = enc(NOP, 2'd0, 2'd0, 8'h00);
    do_reset();
    wait_fetch_at(8'hFF, ok);
    chk("wrap_reach_ff", ok, 1'b1);
    wait_fetch(a, ok);
    chk("wrap_next_ok", ok, 1'b1);
    chk("wrap_next_addr", a, 8'h00);
    wait_halt(cyc);
    chk("wrap_pc", dut.pc, 8'h31);

    // Reset in the middle of a data request.
    clear_prog();
    ddelay = 10;
    imem[8'h00] = enc(LD, 2'd1, 2'd0, 8'h50);
    do_reset();
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      #1;
      if (bus.dmem_req) ok = 1'b1;
    end
    chk("midmem_req_seen", ok, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midmem_req_drop", bus.dmem_req, 1'b0);
    chk("midmem_pc", dut.pc, 8'h00);
    ddelay = 0;
    @(negedge clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
